// File: rtl/nco_tune_wb.sv
// nco_tune_wb: Wishbone-programmable tuning stage for the NCO phase accumulator.
// Produces the per-cycle phase increment, either a fixed tuning word or a
// linear sweep from FREQ toward LIMIT (optionally looping) for chirp output.
module nco_tune_wb #(
   parameter int          BITS     = 16,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_dat_i,
   input  logic [31:0]     wbs_adr_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic [BITS-1:0] incr,
   output logic            run,
   output logic            sweep_done
);

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_FREQ   = 8'h04;
   localparam logic [7:0] OFF_STEP   = 8'h08;
   localparam logic [7:0] OFF_LIMIT  = 8'h0C;
   localparam logic [7:0] OFF_DWELL  = 8'h10;
   localparam logic [7:0] OFF_STATUS = 8'h14;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_SWEEP,
      ST_HOLD
   } state_t;

   // Bus decode
   logic            window_hit;
   logic            valid;
   logic            access;
   logic            wr_en;
   logic [7:0]      offset;
   logic [31:0]     wmask;
   logic [31:0]     rdata;
   logic            ack_reg;
   logic [31:0]     dat_reg;

   // Software-visible registers
   logic [2:0]      ctrl_reg;
   logic [BITS-1:0] freq_reg;
   logic [BITS-1:0] step_reg;
   logic [BITS-1:0] limit_reg;
   logic [15:0]     dwell_reg;
   logic            done_reg;

   // Tuning engine state
   state_t          state_reg;
   logic [BITS-1:0] cur_reg;
   logic [15:0]     dwell_cnt_reg;
   logic            loop_reg;
   logic [BITS-1:0] incr_reg;
   logic            sweep_done_reg;

   // Sweep arithmetic
   logic [BITS:0]   step_sum;
   logic [BITS-1:0] cur_step_next;
   logic            at_limit;
   logic            sweep_end;
   logic            done_set;
   logic            done_clr;
   logic            unused_ok;

   assign window_hit = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign valid      = wbs_cyc_i & wbs_stb_i & window_hit;
   // access is the cycle that raises ack; writes and read capture happen here
   assign access     = valid & ~ack_reg;
   assign wr_en      = access & wbs_we_i;
   assign offset     = wbs_adr_i[7:0];

   // Expand byte-lane selects into a bit mask
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
      end
   endgenerate

   // Upper data/mask bits beyond the register widths are intentionally ignored
   assign unused_ok = ^{wbs_dat_i, wmask};

   // Read-data mux; bits above each field read as zero
   always_comb begin
      rdata = '0;
      case (offset)
         OFF_CTRL:   rdata = 32'(ctrl_reg);
         OFF_FREQ:   rdata = 32'(freq_reg);
         OFF_STEP:   rdata = 32'(step_reg);
         OFF_LIMIT:  rdata = 32'(limit_reg);
         OFF_DWELL:  rdata = 32'(dwell_reg);
         OFF_STATUS: rdata = 32'({done_reg, state_reg == ST_SWEEP});
         default:    rdata = '0;
      endcase
   end

   // Next sweep word, computed one bit wider so a carry saturates at LIMIT
   always_comb begin
      step_sum      = {1'b0, cur_reg} + {1'b0, step_reg};
      cur_step_next = (step_sum > {1'b0, limit_reg}) ? limit_reg : step_sum[BITS-1:0];
   end

   assign at_limit  = (cur_reg >= limit_reg);
   assign sweep_end = (state_reg == ST_SWEEP) && ctrl_reg[0] &&
                      (dwell_cnt_reg == 16'd0) && at_limit;
   assign done_set  = sweep_end & ~loop_reg;
   assign done_clr  = wr_en && (offset == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[1];

   // Wishbone handshake, read data capture and byte-lane register writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_reg   <= 1'b0;
         dat_reg   <= '0;
         ctrl_reg  <= '0;
         freq_reg  <= '0;
         step_reg  <= '0;
         limit_reg <= '0;
         dwell_reg <= '0;
      end else begin
         ack_reg <= access;
         if (access) begin
            dat_reg <= rdata;
         end
         if (wr_en) begin
            case (offset)
               OFF_CTRL:  ctrl_reg  <= (ctrl_reg & ~wmask[2:0]) |
                                       (wbs_dat_i[2:0] & wmask[2:0]);
               OFF_FREQ:  freq_reg  <= (freq_reg & ~wmask[BITS-1:0]) |
                                       (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
               OFF_STEP:  step_reg  <= (step_reg & ~wmask[BITS-1:0]) |
                                       (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
               OFF_LIMIT: limit_reg <= (limit_reg & ~wmask[BITS-1:0]) |
                                       (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
               OFF_DWELL: dwell_reg <= (dwell_reg & ~wmask[15:0]) |
                                       (wbs_dat_i[15:0] & wmask[15:0]);
               default:   ;
            endcase
         end
      end
   end

   // Sticky done flag; a set in the same cycle as a clear wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_reg <= 1'b0;
      end else if (done_set) begin
         done_reg <= 1'b1;
      end else if (done_clr) begin
         done_reg <= 1'b0;
      end
   end

   // Tuning FSM with registered incr and sweep_done outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         cur_reg        <= '0;
         dwell_cnt_reg  <= '0;
         loop_reg       <= 1'b0;
         incr_reg       <= '0;
         sweep_done_reg <= 1'b0;
      end else begin
         sweep_done_reg <= 1'b0;
         if (state_reg != ST_IDLE && !ctrl_reg[0]) begin
            // Disable overrides everything and silences incr immediately
            state_reg <= ST_IDLE;
            incr_reg  <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  incr_reg <= '0;
                  if (ctrl_reg[0]) begin
                     // Mode bits are sampled only on entry from IDLE
                     loop_reg <= ctrl_reg[2];
                     if (ctrl_reg[1]) begin
                        state_reg     <= ST_SWEEP;
                        cur_reg       <= freq_reg;
                        dwell_cnt_reg <= dwell_reg;
                     end else begin
                        state_reg <= ST_RUN;
                     end
                  end
               end
               ST_RUN: begin
                  incr_reg <= freq_reg;
               end
               ST_SWEEP: begin
                  incr_reg <= cur_reg;
                  if (dwell_cnt_reg != 16'd0) begin
                     dwell_cnt_reg <= dwell_cnt_reg - 16'd1;
                  end else if (at_limit) begin
                     if (loop_reg) begin
                        cur_reg       <= freq_reg;
                        dwell_cnt_reg <= dwell_reg;
                     end else begin
                        state_reg      <= ST_HOLD;
                        sweep_done_reg <= 1'b1;
                     end
                  end else begin
                     cur_reg       <= cur_step_next;
                     dwell_cnt_reg <= dwell_reg;
                  end
               end
               ST_HOLD: begin
                  incr_reg <= limit_reg;
               end
               default: begin
                  state_reg <= ST_IDLE;
                  incr_reg  <= '0;
               end
            endcase
         end
      end
   end

   assign wbs_ack_o  = ack_reg;
   assign wbs_dat_o  = dat_reg;
   assign incr       = incr_reg;
   assign run        = (state_reg != ST_IDLE);
   assign sweep_done = sweep_done_reg;

endmodule

// File: tb/tb_nco_tune_wb.sv
// tb_nco_tune_wb: scoreboard bench for the NCO tuning stage.
// Read results and per-cycle incr/sweep_done expectations are queued when
// stimulus is driven and popped when the DUT produces them.
module tb_nco_tune_wb;

   localparam int          BITS = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            wbs_stb_i = 1'b0;
   logic            wbs_cyc_i = 1'b0;
   logic            wbs_we_i = 1'b0;
   logic [3:0]      wbs_sel_i = 4'h0;
   logic [31:0]     wbs_dat_i = '0;
   logic [31:0]     wbs_adr_i = '0;
   logic            wbs_ack_o;
   logic [31:0]     wbs_dat_o;
   logic [BITS-1:0] incr;
   logic            run;
   logic            sweep_done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [15:0] incr;
      logic        done;
   } exp_t;

   logic [31:0] rd_q[$];
   exp_t        cyc_q[$];

   nco_tune_wb #(.BITS(BITS), .BASE_ADR(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
      .incr       (incr),
      .run        (run),
      .sweep_done (sweep_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // One Wishbone access; expects ack exactly one cycle after strobe, one cycle wide
   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] sel, input logic [31:0] exp_rd);
      int          lat;
      logic        got;
      logic [31:0] exp_v;
      logic [31:0] seen;
      @(negedge clk);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = wdata;
      wbs_sel_i = sel;
      if (!we) rd_q.push_back(exp_rd);
      lat  = 0;
      got  = 1'b0;
      seen = '0;
      for (int i = 1; i <= 8 && !got; i++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            got  = 1'b1;
            lat  = i;
            seen = wbs_dat_o;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      if (!got) begin
         check("ack_timeout", 32'd0, 32'd1);
         if (!we) exp_v = rd_q.pop_front();
      end else begin
         check("ack_latency", 32'(lat), 32'd1);
         if (!we) begin
            exp_v = rd_q.pop_front();
            check("rd_data", seen, exp_v);
         end
      end
      @(negedge clk);
      check("ack_pulse", 32'(wbs_ack_o), 32'd0);
      $display("wb %s adr=%h sel=%h dat=%h", we ? "wr" : "rd", adr, sel, we ? wdata : seen);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] data);
      wb_xfer(BASE + 32'(off), 1'b1, data, 4'hF, '0);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp);
      wb_xfer(BASE + 32'(off), 1'b0, '0, 4'hF, exp);
   endtask

   // Reference sweep: each word held dwell+1 cycles, saturating step to limit,
   // done flagged on the final cycle of the last word when not looping.
   task automatic sweep_model(input int freq, input int step, input int limit,
                              input int dwell, input bit lp, input int ncyc);
      int   w;
      int   n;
      exp_t e;
      w = freq;
      n = 0;
      while (n < ncyc) begin
         for (int k = 0; k <= dwell && n < ncyc; k++) begin
            e.incr = 16'(w);
            e.done = (k == dwell) && (w >= limit) && !lp;
            cyc_q.push_back(e);
            n++;
         end
         if (w >= limit) begin
            if (lp) begin
               w = freq;
            end else begin
               while (n < ncyc) begin
                  e.incr = 16'(limit);
                  e.done = 1'b0;
                  cyc_q.push_back(e);
                  n++;
               end
            end
         end else begin
            w = (w + step > limit) ? limit : w + step;
         end
      end
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         e = cyc_q.pop_front();
         check("incr", 32'(incr), 32'(e.incr));
         check("sweep_done", 32'(sweep_done), 32'(e.done));
         check("run", 32'(run), 32'd1);
      end
      $display("sweep freq=%h step=%h limit=%h dwell=%0d loop=%0d cycles=%0d",
               freq, step, limit, dwell, lp, ncyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_incr", 32'(incr), 32'd0);
      check("rst_run", 32'(run), 32'd0);
      check("rst_ack", 32'(wbs_ack_o), 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_done", 32'(sweep_done), 32'd0);
      rst_n = 1'b1;

      // Every offset reads zero after reset, including an unmapped one
      for (int off = 0; off <= 8'h18; off += 4) rd(8'(off), 32'd0);

      // Byte lanes, field width and unmapped writes
      wr(8'h04, 32'h0000_1234);
      wb_xfer(BASE + 32'h04, 1'b1, 32'h0000_ABCD, 4'b0001, '0);
      rd(8'h04, 32'h0000_12CD);
      wr(8'h08, 32'hFFFF_FFFF);
      rd(8'h08, 32'h0000_FFFF);
      wr(8'h18, 32'hFFFF_FFFF);
      rd(8'h18, 32'd0);

      // Fixed mode
      wr(8'h04, 32'h0123);
      wr(8'h00, 32'h1);
      check("run_on", 32'(run), 32'd1);
      check("incr_lag", 32'(incr), 32'd0);
      @(negedge clk);
      check("incr_fixed", 32'(incr), 32'h0123);
      wr(8'h04, 32'h0200);
      check("incr_retune", 32'(incr), 32'h0200);
      wr(8'h00, 32'h0);
      check("incr_off", 32'(incr), 32'd0);
      check("run_off", 32'(run), 32'd0);

      // Non-looping sweep to HOLD
      wr(8'h04, 32'h0010);
      wr(8'h08, 32'h0010);
      wr(8'h0C, 32'h0040);
      wr(8'h10, 32'd2);
      wr(8'h00, 32'h3);
      check("sweep_start", 32'(incr), 32'd0);
      sweep_model(16'h10, 16'h10, 16'h40, 2, 1'b0, 16);
      rd(8'h14, 32'h2);
      wr(8'h14, 32'h2);
      rd(8'h14, 32'h0);
      wr(8'h00, 32'h0);
      check("run_off2", 32'(run), 32'd0);

      // Looping sweep
      wr(8'h00, 32'h7);
      check("loop_start", 32'(incr), 32'd0);
      sweep_model(16'h10, 16'h10, 16'h40, 2, 1'b1, 20);
      rd(8'h14, 32'h1);

      // Asynchronous reset while an access is being acked mid-sweep
      @(negedge clk);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = BASE + 32'h14;
      @(negedge clk);
      check("ack_before_rst", 32'(wbs_ack_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_incr", 32'(incr), 32'd0);
      check("arst_run", 32'(run), 32'd0);
      check("arst_ack", 32'(wbs_ack_o), 32'd0);
      check("arst_dat", wbs_dat_o, 32'd0);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      $display("async reset asserted mid-sweep");
      @(negedge clk);
      rst_n = 1'b1;
      rd(8'h04, 32'd0);
      rd(8'h00, 32'd0);

      // Saturating sweep near full scale
      wr(8'h04, 32'hFFF0);
      wr(8'h08, 32'h0020);
      wr(8'h0C, 32'hFFFF);
      wr(8'h10, 32'd0);
      wr(8'h00, 32'h3);
      sweep_model(16'hFFF0, 16'h20, 16'hFFFF, 0, 1'b0, 6);
      wr(8'h00, 32'h0);

      // Access outside the window: no ack, no state change
      @(negedge clk);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b1;
      wbs_adr_i = BASE + 32'h100;
      wbs_dat_i = 32'h1;
      wbs_sel_i = 4'hF;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (wbs_ack_o) acks++;
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      $display("wb wr adr=%h outside window", BASE + 32'h100);
      check("oow_ack", 32'(acks), 32'd0);
      check("oow_run", 32'(run), 32'd0);
      rd(8'h00, 32'd0);
      rd(8'h04, 32'hFFF0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nco_tune_wb.md
Name: nco_tune_wb

Overview:
Wishbone-controlled tuning stage directly upstream of the phase-accumulator counter. It produces the per-cycle phase increment that feeds the accumulator's incr input. In fixed mode it holds a programmed tuning word. In sweep mode it steps that word linearly toward a limit for chirp generation through the CORDIC and sigma-delta DAC chain.

Parameters:
BITS, 16, width of the tuning word and of the incr output
BASE_ADR, 32'h3000_0000, Wishbone window base; the block decodes adr[31:8] == BASE_ADR[31:8]

Ports:
clk  input  1  system clock (Wishbone clock)
rst_n  input  1  asynchronous active-low reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  Wishbone write enable
wbs_sel_i  input  4  byte-lane selects
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  byte address
wbs_ack_o  output  1  Wishbone acknowledge
wbs_dat_o  output  32  read data
incr  output  BITS  phase increment to the accumulator, registered
run  output  1  high while the state is not IDLE
sweep_done  output  1  one-cycle pulse when a non-looping sweep reaches the limit

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared to 0; state = IDLE.
  - incr = 0, run = 0, sweep_done = 0, wbs_ack_o = 0, wbs_dat_o = 0.
- Register map (offset = adr[7:0]; bits above BITS-1 read 0):
  - 0x00 CTRL: bit0 enable, bit1 sweep_en, bit2 loop.
  - 0x04 FREQ: start/fixed tuning word.
  - 0x08 STEP: sweep step.
  - 0x0C LIMIT: sweep end word.
  - 0x10 DWELL: extra cycles per step, 16 bits.
  - 0x14 STATUS: bit0 sweeping (read-only), bit1 done (sticky; write 1 to clear).
- Wishbone handshake:
  - valid = cyc & stb & window hit.
  - wbs_ack_o <= valid & ~wbs_ack_o, so ack is a single-cycle pulse one cycle after valid; back-to-back accesses ack every other cycle.
  - A write commits on the ack cycle, per byte lane from wbs_sel_i.
  - wbs_dat_o is registered with ack.
  - Unmapped offsets inside the window ack, read 0 and ignore writes.
  - Outside the window: no ack and no state change.
- FSM, evaluated every clk:
  - IDLE: incr = 0.
    - If enable=1 and sweep_en=0: go to RUN.
    - If enable=1 and sweep_en=1: go to SWEEP; load cur = FREQ and dwell_cnt = DWELL.
  - RUN: incr = FREQ.
    - A FREQ write is visible on incr the cycle after its ack.
  - SWEEP: incr = cur.
    - Each cycle: if dwell_cnt != 0, decrement it.
    - Otherwise: if cur >= LIMIT, the sweep endpoint is reached. Else cur = min(cur + STEP, LIMIT), computed in BITS+1 bits so carry saturates to LIMIT; then dwell_cnt = DWELL.
    - Each word is therefore held DWELL+1 cycles.
    - At the endpoint with loop=1: cur = FREQ, dwell_cnt = DWELL, stay in SWEEP; no done pulse.
    - At the endpoint with loop=0: go to HOLD; sweep_done pulses once; STATUS.done set.
  - HOLD: incr = LIMIT held.
  - From RUN, SWEEP or HOLD, enable=0 returns to IDLE on the next cycle (incr = 0). This takes priority over all other transitions.
- Boundary cases:
  - FREQ >= LIMIT at sweep start: the endpoint is reached after the first dwell.
  - STEP = 0 with FREQ < LIMIT: the sweep never ends; this is legal.
  - CTRL writes to sweep_en or loop while not IDLE take effect only on the next entry from IDLE.
  - A STATUS.done clear that coincides with a set: set wins.
  - rst_n asserted mid-sweep: immediate return to reset values.
- run = (state != IDLE). STATUS.sweeping = (state == SWEEP).

Test Plan:
- Reset then read all offsets → every read returns 0; each access gives exactly one ack pulse, one cycle after stb.
- Write FREQ=0x0123, CTRL=0x1 → incr=0x0123 from the second cycle after the CTRL ack, run=1. Write FREQ=0x0200 → incr=0x0200 the cycle after that ack. CTRL=0 → incr=0, run=0.
- FREQ=0x0010, STEP=0x0010, LIMIT=0x0040, DWELL=2, CTRL=0x3 → incr sequence 0x10, 0x20, 0x30, 0x40, each held 3 cycles. Then one sweep_done pulse, HOLD at 0x40, STATUS reads 0x2. Write STATUS=0x2 → STATUS reads 0.
- Same setup with CTRL=0x7 → after 0x40 is held 3 cycles, incr returns to 0x10; sweep_done never pulses.
- FREQ=0xFFF0, STEP=0x0020, LIMIT=0xFFFF, DWELL=0 → incr 0xFFF0 then 0xFFFF (saturated, no wrap), then HOLD.
- Pull rst_n low mid-sweep (asynchronously, between clk edges) → incr=0, run=0, ack=0 immediately. Access outside the window (adr=0x3000_0100) → no ack and registers unchanged.
